// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the MIPS pipeline stages.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_core.sv
// 2-read / 1-write architectural register array with async active-low clear.
// Register $0 is never written and always reads zero.
module regfile_core
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int NREG   = mips_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != REG_ZERO)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = (ra1 == REG_ZERO) ? '0 : regs_q[ra1];
        rd2 = (ra2 == REG_ZERO) ? '0 : regs_q[ra2];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects write data/destination, commits to regfile_core, counts retired writes.
// Define WB_BYPASS_EN to forward the in-flight write to matching read ports in the same cycle.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int NREG   = mips_pkg::NREG,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic              RegDst_in,
    input  logic [ADDR_W-1:0] RegAddrI_in,
    input  logic [ADDR_W-1:0] RegAddrR_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic [ADDR_W-1:0] ra1_in,
    input  logic [ADDR_W-1:0] ra2_in,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [ADDR_W-1:0] wb_addr_out,
    output logic              wb_we_out,
    output logic [CNT_W-1:0]  wb_count_out
);

    logic [DATA_W-1:0] core_rd1;
    logic [DATA_W-1:0] core_rd2;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    always_comb begin
        wb_data_out = MemToReg_in ? mem_in : ALUresult_in;
        wb_addr_out = RegDst_in ? RegAddrR_in : RegAddrI_in;
        wb_we_out   = RegWrite_in && (wb_addr_out != REG_ZERO);
    end

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_core (
        .clk   (clk),
        .rst_n (rst),
        .we    (wb_we_out),
        .waddr (wb_addr_out),
        .wdata (wb_data_out),
        .ra1   (ra1_in),
        .ra2   (ra2_in),
        .rd1   (core_rd1),
        .rd2   (core_rd2)
    );

    // Counter wraps naturally at all-ones.
    always_comb begin
        count_d = count_q;
        if (wb_we_out) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wb_count_out = count_q;

`ifdef WB_BYPASS_EN
    // Forward only while out of reset so reads stay zero during clear.
    always_comb begin
        rd1_out = core_rd1;
        rd2_out = core_rd2;
        if (rst && wb_we_out && (ra1_in == wb_addr_out)) begin
            rd1_out = wb_data_out;
        end
        if (rst && wb_we_out && (ra2_in == wb_addr_out)) begin
            rd2_out = wb_data_out;
        end
    end
`else
    always_comb begin
        rd1_out = core_rd1;
        rd2_out = core_rd2;
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table vectors, directed corner cases, random stream vs model.
module tb_wb_regfile;

    localparam int CNT_W = 8;

    logic        clk;
    logic        rst;
    logic [31:0] ALUresult_in;
    logic [31:0] mem_in;
    logic        RegDst_in;
    logic [4:0]  RegAddrI_in;
    logic [4:0]  RegAddrR_in;
    logic        RegWrite_in;
    logic        MemToReg_in;
    logic [4:0]  ra1_in;
    logic [4:0]  ra2_in;
    logic [31:0] rd1_out;
    logic [31:0] rd2_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_addr_out;
    logic        wb_we_out;
    logic [CNT_W-1:0] wb_count_out;

    wb_regfile #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALUresult_in (ALUresult_in),
        .mem_in       (mem_in),
        .RegDst_in    (RegDst_in),
        .RegAddrI_in  (RegAddrI_in),
        .RegAddrR_in  (RegAddrR_in),
        .RegWrite_in  (RegWrite_in),
        .MemToReg_in  (MemToReg_in),
        .ra1_in       (ra1_in),
        .ra2_in       (ra2_in),
        .rd1_out      (rd1_out),
        .rd2_out      (rd2_out),
        .wb_data_out  (wb_data_out),
        .wb_addr_out  (wb_addr_out),
        .wb_we_out    (wb_we_out),
        .wb_count_out (wb_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural register contents and number of retired writes.
    logic [31:0] mdl [32];
    int          mdl_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_data();
        return MemToReg_in ? mem_in : ALUresult_in;
    endfunction

    function automatic logic [4:0] sel_addr();
        return RegDst_in ? RegAddrR_in : RegAddrI_in;
    endfunction

    function automatic logic sel_we();
        return RegWrite_in && (sel_addr() != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (!rst) return 32'd0;
`ifdef WB_BYPASS_EN
        if (sel_we() && ra == sel_addr()) return sel_data();
`endif
        return mdl[ra];
    endfunction

    task automatic set_in(input logic [31:0] alu, input logic [31:0] mem, input logic rdst,
                          input logic [4:0] rai, input logic [4:0] rar, input logic rw,
                          input logic m2r, input logic [4:0] a1, input logic [4:0] a2);
        ALUresult_in = alu;
        mem_in       = mem;
        RegDst_in    = rdst;
        RegAddrI_in  = rai;
        RegAddrR_in  = rar;
        RegWrite_in  = rw;
        MemToReg_in  = m2r;
        ra1_in       = a1;
        ra2_in       = a2;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_wb_data"}, wb_data_out, sel_data());
        chk({tag, "_wb_addr"}, {27'd0, wb_addr_out}, {27'd0, sel_addr()});
        chk({tag, "_wb_we"}, {31'd0, wb_we_out}, {31'd0, sel_we()});
        chk({tag, "_rd1"}, rd1_out, exp_rd(ra1_in));
        chk({tag, "_rd2"}, rd2_out, exp_rd(ra2_in));
        chk({tag, "_count"}, {24'd0, wb_count_out}, {24'd0, 8'(mdl_cnt)});
    endtask

    // One pipeline cycle: drive at negedge, check pre-commit, commit at posedge, check post-commit.
    task automatic step(input string tag, input logic [31:0] alu, input logic [31:0] mem,
                        input logic rdst, input logic [4:0] rai, input logic [4:0] rar,
                        input logic rw, input logic m2r, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        set_in(alu, mem, rdst, rai, rar, rw, m2r, a1, a2);
        #1;
        check_all({tag, "_pre"});
        @(posedge clk);
        if (rst && sel_we()) begin
            mdl[sel_addr()] = sel_data();
            mdl_cnt++;
        end
        #1;
        check_all({tag, "_post"});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl_cnt = 0;
    endtask

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic        rdst;
        logic [4:0]  rai;
        logic [4:0]  rar;
        logic        rw;
        logic        m2r;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic        e_we;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 5'd0,  5'd5,  1'b1, 1'b0, 32'hDEAD_BEEF, 5'd5,  1'b1};
        vecs[1] = '{32'h1111_1111, 32'h1234_5678, 1'b0, 5'd9,  5'd3,  1'b1, 1'b1, 32'h1234_5678, 5'd9,  1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5'd4,  5'd0,  1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0};
        vecs[3] = '{32'hCAFE_0001, 32'h0BAD_0002, 1'b0, 5'd12, 5'd13, 1'b0, 1'b0, 32'hCAFE_0001, 5'd12, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h55AA_55AA, 1'b1, 5'd0,  5'd31, 1'b1, 1'b1, 32'h55AA_55AA, 5'd31, 1'b1};
        vecs[5] = '{32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 5'd0,  5'd17, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0,  1'b0};

        model_clear();
        rst = 1'b0;
        set_in(32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset state: every register reads zero, counter zero.
        for (int i = 0; i < 32; i++) begin
            ra1_in = 5'(i);
            ra2_in = 5'(31 - i);
            #1;
            chk("reset_rd1", rd1_out, 32'd0);
            chk("reset_rd2", rd2_out, 32'd0);
        end
        chk("reset_count", {24'd0, wb_count_out}, 32'd0);

        // Table vectors: mux selection and $0 masking against constants, then commit via model.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(vecs[i].alu, vecs[i].mem, vecs[i].rdst, vecs[i].rai, vecs[i].rar,
                   vecs[i].rw, vecs[i].m2r, vecs[i].e_addr, 5'd0);
            #1;
            chk("vec_data", wb_data_out, vecs[i].e_data);
            chk("vec_addr", {27'd0, wb_addr_out}, {27'd0, vecs[i].e_addr});
            chk("vec_we", {31'd0, wb_we_out}, {31'd0, vecs[i].e_we});
            @(posedge clk);
            if (vecs[i].e_we) begin
                mdl[vecs[i].e_addr] = vecs[i].e_data;
                mdl_cnt++;
            end
            #1;
            chk("vec_rd_after", rd1_out, (vecs[i].e_addr == 5'd0) ? 32'd0 : mdl[vecs[i].e_addr]);
            chk("vec_count", {24'd0, wb_count_out}, {24'd0, 8'(mdl_cnt)});
        end
        chk("vec_r5", mdl[5], 32'hDEAD_BEEF);
        chk("vec_count_total", {24'd0, wb_count_out}, 32'd3);

        // Same-cycle read of the write target.
        step("pre7", 32'h0000_0011, 32'd0, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd1, 5'd2);
        @(negedge clk);
        set_in(32'h0000_00A5, 32'd0, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd7, 5'd7);
        #1;
`ifdef WB_BYPASS_EN
        chk("same_cycle_rd1", rd1_out, 32'h0000_00A5);
        chk("same_cycle_rd2", rd2_out, 32'h0000_00A5);
`else
        chk("same_cycle_rd1", rd1_out, 32'h0000_0011);
        chk("same_cycle_rd2", rd2_out, 32'h0000_0011);
`endif
        @(posedge clk);
        mdl[7] = 32'h0000_00A5;
        mdl_cnt++;
        #1;
        chk("after_edge_rd1", rd1_out, 32'h0000_00A5);
        chk("after_edge_rd2", rd2_out, 32'h0000_00A5);

        // Async reset between edges while a write is pending.
        step("pre_r3", 32'h0000_3333, 32'd0, 1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 5'd3, 5'd5);
        @(negedge clk);
        set_in(32'h0000_0077, 32'd0, 1'b1, 5'd0, 5'd4, 1'b1, 1'b0, 5'd3, 5'd5);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk("arst_rd1", rd1_out, 32'd0);
        chk("arst_rd2", rd2_out, 32'd0);
        chk("arst_count", {24'd0, wb_count_out}, 32'd0);
        chk("arst_we_follows", {31'd0, wb_we_out}, 32'd1);
        @(posedge clk);
        #1;
        chk("arst_no_commit_count", {24'd0, wb_count_out}, 32'd0);
        @(negedge clk);
        RegWrite_in = 1'b0;
        ra2_in = 5'd4;
        #1;
        chk("arst_no_commit_r4", rd2_out, 32'd0);
        rst = 1'b1;
        step("first_commit", 32'h0000_0077, 32'd0, 1'b1, 5'd0, 5'd4, 1'b1, 1'b0, 5'd4, 5'd3);
        chk("first_commit_count", {24'd0, wb_count_out}, 32'd1);

        // Random stream; enough writes to wrap the 8-bit counter.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rai, rar, a1, a2;
            logic rdst;
            rai  = 5'($urandom_range(0, 31));
            rar  = 5'($urandom_range(0, 31));
            rdst = 1'($urandom);
            a1   = ($urandom_range(0, 3) == 0) ? (rdst ? rar : rai) : 5'($urandom_range(0, 31));
            a2   = ($urandom_range(0, 3) == 0) ? (rdst ? rar : rai) : 5'($urandom_range(0, 31));
            step("rand", $urandom, $urandom, rdst, rai, rar,
                 ($urandom_range(0, 3) != 0), 1'($urandom), a1, a2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
